// File: rtl/sorter_array_v3.sv
// sorter_array_v3: DEPTH-slot key/payload array kept sorted at all times.
// One insert per cycle, head popped via valid/ready, insert and pop may
// happen together. Each slot compares its own key against the incoming key
// and then selects its new value from itself, a neighbour or the input.
module sorter_array_v3 #(
  parameter int DEPTH      = 16,
  parameter int KEY_W      = 16,
  parameter int PAY_W      = 16,
  parameter int DESCENDING = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [KEY_W-1:0]                 in_key,
  input  logic [PAY_W-1:0]                 in_payload,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [KEY_W-1:0]                 out_key,
  output logic [PAY_W-1:0]                 out_payload,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic [DEPTH-1:0][KEY_W-1:0]      view_key,
  output logic [DEPTH-1:0][PAY_W-1:0]      view_payload,
  output logic [DEPTH-1:0]                 view_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][KEY_W-1:0] key_q, key_d, key_up, key_dn;
  logic [DEPTH-1:0][PAY_W-1:0] pay_q, pay_d, pay_up, pay_dn;
  logic [DEPTH-1:0]            valid_q, valid_d, valid_up, valid_dn;
  logic [CW-1:0]               count_q, count_d;

  // ge[j]: the new entry belongs at or before slot j (slot empty or key
  // strictly beyond in_key). Sorted + thermometer valid makes ge a
  // thermometer too; ge[DEPTH] stands for the empty space past the end.
  logic [DEPTH:0]   ge;
  logic [DEPTH-1:0] ge_dn;   // ge of the slot above (towards the head)
  logic [DEPTH-1:0] ge_pop;  // ge of slot j, forced 0 at the popped head
  logic             ins, pop;

  assign full        = (count_q == CW'(DEPTH));
  assign in_ready    = ~full;
  assign out_valid   = valid_q[0];
  assign out_key     = key_q[0];
  assign out_payload = pay_q[0];
  assign count       = count_q;
  assign view_key    = key_q;
  assign view_payload = pay_q;
  assign view_valid  = valid_q;

  assign ins = in_valid & ~full;
  assign pop = valid_q[0] & out_ready;

  assign key_up   = {KEY_W'(0), key_q[DEPTH-1:1]};
  assign pay_up   = {PAY_W'(0), pay_q[DEPTH-1:1]};
  assign valid_up = {1'b0, valid_q[DEPTH-1:1]};
  assign key_dn   = {key_q[DEPTH-2:0], KEY_W'(0)};
  assign pay_dn   = {pay_q[DEPTH-2:0], PAY_W'(0)};
  assign valid_dn = {valid_q[DEPTH-2:0], 1'b0};
  assign ge_dn    = {ge[DEPTH-2:0], 1'b0};
  assign ge_pop   = {ge[DEPTH-1:1], 1'b0};

  // Local per-slot comparison against the incoming key
  always_comb begin
    ge        = '0;
    ge[DEPTH] = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      if (DESCENDING != 0) ge[j] = ~valid_q[j] | (key_q[j] < in_key);
      else                 ge[j] = ~valid_q[j] | (key_q[j] > in_key);
    end
  end

  // Per-slot source select: hold, neighbour below (pop), neighbour above
  // (insert shift) or the input; with a pop, slot j looks at old slot j+1
  always_comb begin
    key_d   = key_q;
    pay_d   = pay_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ins && pop) begin
          if (ge[j+1] && !ge_pop[j]) begin
            key_d[j] = in_key;  pay_d[j] = in_payload;  valid_d[j] = 1'b1;
          end else if (!ge[j+1]) begin
            key_d[j] = key_up[j];  pay_d[j] = pay_up[j];  valid_d[j] = valid_up[j];
          end
        end else if (ins) begin
          if (ge[j] && !ge_dn[j]) begin
            key_d[j] = in_key;  pay_d[j] = in_payload;  valid_d[j] = 1'b1;
          end else if (ge[j]) begin
            key_d[j] = key_dn[j];  pay_d[j] = pay_dn[j];  valid_d[j] = valid_dn[j];
          end
        end else if (pop) begin
          key_d[j] = key_up[j];  pay_d[j] = pay_up[j];  valid_d[j] = valid_up[j];
        end
      end
      count_d = count_q + CW'(ins) - CW'(pop);
    end
  end

  // Slot and occupancy registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q   <= '0;
      pay_q   <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      key_q   <= key_d;
      pay_q   <= pay_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sorter_array_v3.sv
// Bench for sorter_array_v3: three instances (ascending/4, descending/4,
// ascending/16) share one input stream and are each checked every cycle
// against a queue-based model, plus directed scenarios with fixed values.
module tb_sorter_array_v3;

  localparam int NI = 3;

  typedef struct {
    logic [15:0] key;
    logic [15:0] pay;
  } entry_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_key, in_payload;

  logic             r0_in_ready, r0_out_valid, r0_full;
  logic [15:0]      r0_out_key, r0_out_pay;
  logic [2:0]       r0_count;
  logic [3:0][15:0] r0_vk, r0_vp;
  logic [3:0]       r0_vv;

  logic             r1_in_ready, r1_out_valid, r1_full;
  logic [15:0]      r1_out_key, r1_out_pay;
  logic [2:0]       r1_count;
  logic [3:0][15:0] r1_vk, r1_vp;
  logic [3:0]       r1_vv;

  logic              r2_in_ready, r2_out_valid, r2_full;
  logic [15:0]       r2_out_key, r2_out_pay;
  logic [4:0]        r2_count;
  logic [15:0][15:0] r2_vk, r2_vp;
  logic [15:0]       r2_vv;

  sorter_array_v3 #(.DEPTH(4), .KEY_W(16), .PAY_W(16), .DESCENDING(0)) u_asc4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_key(in_key), .in_payload(in_payload), .in_valid(in_valid), .in_ready(r0_in_ready),
    .out_key(r0_out_key), .out_payload(r0_out_pay), .out_valid(r0_out_valid), .out_ready(out_ready),
    .count(r0_count), .full(r0_full), .view_key(r0_vk), .view_payload(r0_vp), .view_valid(r0_vv));

  sorter_array_v3 #(.DEPTH(4), .KEY_W(16), .PAY_W(16), .DESCENDING(1)) u_dsc4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_key(in_key), .in_payload(in_payload), .in_valid(in_valid), .in_ready(r1_in_ready),
    .out_key(r1_out_key), .out_payload(r1_out_pay), .out_valid(r1_out_valid), .out_ready(out_ready),
    .count(r1_count), .full(r1_full), .view_key(r1_vk), .view_payload(r1_vp), .view_valid(r1_vv));

  sorter_array_v3 #(.DEPTH(16), .KEY_W(16), .PAY_W(16), .DESCENDING(0)) u_asc16 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_key(in_key), .in_payload(in_payload), .in_valid(in_valid), .in_ready(r2_in_ready),
    .out_key(r2_out_key), .out_payload(r2_out_pay), .out_valid(r2_out_valid), .out_ready(out_ready),
    .count(r2_count), .full(r2_full), .view_key(r2_vk), .view_payload(r2_vp), .view_valid(r2_vv));

  entry_t mq[NI][$];
  int     dep[NI] = '{4, 4, 16};
  int     dsc[NI] = '{0, 1, 0};
  int     n_checks = 0;
  int     n_fails  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int d, output logic [255:0] vk, output logic [255:0] vp,
                      output logic [15:0] vv, output int cnt, output logic ov,
                      output logic ir, output logic fu, output logic [15:0] ok,
                      output logic [15:0] op);
    vk = '0; vp = '0; vv = '0;
    case (d)
      0: begin
        vk[63:0] = r0_vk; vp[63:0] = r0_vp; vv[3:0] = r0_vv; cnt = int'(r0_count);
        ov = r0_out_valid; ir = r0_in_ready; fu = r0_full; ok = r0_out_key; op = r0_out_pay;
      end
      1: begin
        vk[63:0] = r1_vk; vp[63:0] = r1_vp; vv[3:0] = r1_vv; cnt = int'(r1_count);
        ov = r1_out_valid; ir = r1_in_ready; fu = r1_full; ok = r1_out_key; op = r1_out_pay;
      end
      default: begin
        vk = r2_vk; vp = r2_vp; vv = r2_vv; cnt = int'(r2_count);
        ov = r2_out_valid; ir = r2_in_ready; fu = r2_full; ok = r2_out_key; op = r2_out_pay;
      end
    endcase
  endtask

  // Reference: a sorted list; a new entry goes after every remaining entry
  // whose key is not beyond it, so equal keys stay in arrival order.
  task automatic model_step(input int d);
    entry_t e;
    int     pos;
    bit     ins, pop, found;
    if (reset || flush) begin
      mq[d].delete();
    end else begin
      ins = in_valid && (mq[d].size() < dep[d]);
      pop = out_ready && (mq[d].size() > 0);
      if (pop) void'(mq[d].pop_front());
      if (ins) begin
        e.key = in_key;
        e.pay = in_payload;
        pos   = mq[d].size();
        found = 1'b0;
        for (int i = 0; i < mq[d].size(); i++) begin
          if (!found && (dsc[d] != 0 ? mq[d][i].key < in_key : mq[d][i].key > in_key)) begin
            pos   = i;
            found = 1'b1;
          end
        end
        mq[d].insert(pos, e);
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [255:0] vk, vp, evk, evp, m;
    logic [15:0]  vv, evv, ok, op;
    logic         ov, ir, fu;
    int           cnt, n;
    snap(d, vk, vp, vv, cnt, ov, ir, fu, ok, op);
    n = mq[d].size();
    evk = '0; evp = '0; evv = '0; m = '0;
    for (int i = 0; i < n; i++) begin
      evk[i*16 +: 16] = mq[d][i].key;
      evp[i*16 +: 16] = mq[d][i].pay;
      evv[i]          = 1'b1;
      m[i*16 +: 16]   = 16'hFFFF;
    end
    check($sformatf("d%0d_count", d), 256'(cnt), 256'(n));
    check($sformatf("d%0d_view_valid", d), 256'(vv), 256'(evv));
    check($sformatf("d%0d_view_key", d), vk & m, evk);
    check($sformatf("d%0d_view_payload", d), vp & m, evp);
    check($sformatf("d%0d_out_valid", d), 256'(ov), 256'(n > 0));
    check($sformatf("d%0d_in_ready", d), 256'(ir), 256'(n < dep[d]));
    check($sformatf("d%0d_full", d), 256'(fu), 256'(n == dep[d]));
    if (n > 0) begin
      check($sformatf("d%0d_out_key", d), 256'(ok), 256'(mq[d][0].key));
      check($sformatf("d%0d_out_payload", d), 256'(op), 256'(mq[d][0].pay));
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [15:0] k, input logic [15:0] p, input logic ordy);
    reset = r; flush = f; in_valid = iv; in_key = k; in_payload = p; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clock);
    for (int d = 0; d < NI; d++) model_step(d);
    #1;
    for (int d = 0; d < NI; d++) check_dut(d);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic insert_keys(input int ks[4], input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(ks[i]), 16'(16'h0100 + ks[i]), 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [255:0] vk, vp;
    logic [15:0]  vv, ok, op;
    logic         ov, ir, fu;
    int           cnt;
    int           ks[4];
    int           pi_ins, pi_pop;

    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clock);

    // reset values, including cleared key/payload registers
    do_reset();
    for (int d = 0; d < NI; d++) begin
      snap(d, vk, vp, vv, cnt, ov, ir, fu, ok, op);
      check($sformatf("rst_keys_d%0d", d), vk, 256'(0));
      check($sformatf("rst_pays_d%0d", d), vp, 256'(0));
      check($sformatf("rst_in_ready_d%0d", d), 256'(ir), 256'(1));
    end

    // ascending, stable ties: 5,3(A),9,3(B)
    ks = '{5, 3, 9, 3};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(ks[i]), (i == 1) ? 16'hA : (i == 3) ? 16'hB : 16'(ks[i]), 1'b0);
      check("t1_in_ready", 256'(r0_in_ready), 256'(1));
      tick();
    end
    check("t1_keys", 256'(r0_vk), 256'(64'h0009_0005_0003_0003));
    check("t1_pay0", 256'(r0_vp[0]), 256'(16'hA));
    check("t1_pay1", 256'(r0_vp[1]), 256'(16'hB));
    check("t1_count", 256'(r0_count), 256'(4));

    // descending, DEPTH 4: 1,7,4,7 fills it, 2 is refused
    do_reset();
    ks = '{1, 7, 4, 7};
    insert_keys(ks, 4);
    check("t2_keys", 256'(r1_vk), 256'(64'h0001_0004_0007_0007));
    check("t2_full", 256'(r1_full), 256'(1));
    check("t2_in_ready", 256'(r1_in_ready), 256'(0));
    drive(1'b0, 1'b0, 1'b1, 16'd2, 16'h0102, 1'b0);
    tick();
    check("t2_keys_after_refuse", 256'(r1_vk), 256'(64'h0001_0004_0007_0007));
    check("t2_count_after_refuse", 256'(r1_count), 256'(4));

    // 2,6,8 + insert 1 with pop
    do_reset();
    ks = '{2, 6, 8, 0};
    insert_keys(ks, 3);
    drive(1'b0, 1'b0, 1'b1, 16'd1, 16'h0101, 1'b1);
    check("t3_pop_key", 256'(r0_out_key), 256'(2));
    tick();
    check("t3_keys", 256'(r0_vk[2:0]), 256'(48'h0008_0006_0001));
    check("t3_count", 256'(r0_count), 256'(3));

    // 2,6,8 + insert 7 with pop
    do_reset();
    insert_keys(ks, 3);
    drive(1'b0, 1'b0, 1'b1, 16'd7, 16'h0107, 1'b1);
    tick();
    check("t4_keys", 256'(r0_vk[2:0]), 256'(48'h0008_0007_0006));
    check("t4_count", 256'(r0_count), 256'(3));

    // full DEPTH 4: pop with in_valid, insert refused, then lands
    do_reset();
    ks = '{4, 2, 8, 6};
    insert_keys(ks, 4);
    drive(1'b0, 1'b0, 1'b1, 16'd5, 16'h0105, 1'b1);
    check("t5_in_ready_full", 256'(r0_in_ready), 256'(0));
    tick();
    check("t5_count_after_pop", 256'(r0_count), 256'(3));
    check("t5_in_ready_after_pop", 256'(r0_in_ready), 256'(1));
    check("t5_keys_after_pop", 256'(r0_vk[2:0]), 256'(48'h0008_0006_0004));
    drive(1'b0, 1'b0, 1'b1, 16'd5, 16'h0105, 1'b0);
    tick();
    check("t5_keys_after_ins", 256'(r0_vk), 256'(64'h0008_0006_0005_0004));

    // flush with insert+pop, then reset mid-stream with insert+pop
    do_reset();
    ks = '{3, 1, 2, 0};
    insert_keys(ks, 3);
    drive(1'b0, 1'b1, 1'b1, 16'd0, 16'h0100, 1'b1);
    tick();
    check("t6_flush_count", 256'(r0_count), 256'(0));
    check("t6_flush_out_valid", 256'(r0_out_valid), 256'(0));
    check("t6_flush_view_valid", 256'(r0_vv), 256'(0));
    insert_keys(ks, 2);
    drive(1'b1, 1'b1, 1'b1, 16'd9, 16'h0109, 1'b1);
    tick();
    check("t6_reset_count", 256'(r0_count), 256'(0));
    check("t6_reset_out_valid", 256'(r0_out_valid), 256'(0));
    check("t6_reset_view_valid", 256'(r2_vv), 256'(0));

    // randomized traffic in three fill/drain phases
    for (int c = 0; c < 3000; c++) begin
      pi_ins = (c < 1000) ? 80 : (c < 2000) ? 55 : 30;
      pi_pop = (c < 1000) ? 25 : (c < 2000) ? 50 : 70;
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 119) == 0,
            $urandom_range(0, 99) < pi_ins,
            16'($urandom_range(0, 20)),
            16'($urandom),
            $urandom_range(0, 99) < pi_pop);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sorter_array_v3.md
Name: sorter_array_v3

Overview:
- Parametrised successor to the systolic insertion sorter: a DEPTH-entry array of key/payload slots kept continuously sorted.
- Accepts one insertion per cycle. The old block accepted one every other cycle.
- Pops the head entry through a valid/ready stream, supports a same-cycle insert and pop, and has a synchronous flush.
- Exposes a parallel per-slot view for the downstream memory-match logic. Sits between the ingress parser and the match/priority stage.

Parameters:
- DEPTH, 16, number of slots (≥2).
- KEY_W, 16, sort key width.
- PAY_W, 16, payload width carried with each key; not compared.
- DESCENDING, 0, 0 = slot 0 holds the smallest key; 1 = slot 0 holds the largest key.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all entries.
- in_key  in  KEY_W  key to insert.
- in_payload  in  PAY_W  payload to insert.
- in_valid  in  1  insert request.
- in_ready  out  1  array can accept an insert this cycle.
- out_key  out  KEY_W  head slot key.
- out_payload  out  PAY_W  head slot payload.
- out_valid  out  1  head slot occupied.
- out_ready  in  1  consumer pops the head.
- count  out  $clog2(DEPTH+1)  number of occupied slots.
- full  out  1  count == DEPTH.
- view_key  out  KEY_W x [DEPTH]  per-slot keys, slot 0 = head.
- view_payload  out  PAY_W x [DEPTH]  per-slot payloads.
- view_valid  out  1 x [DEPTH]  per-slot occupied flags.

Behaviour:
- Reset: count=0, all view_valid=0, all keys/payloads=0. Outputs: out_valid=0, full=0, in_ready=1.
- Reset overrides flush, which overrides insert/pop.
- Flush: same reset effect on the next edge, but key/payload registers may keep stale data. Any insert or pop in the flush cycle is discarded.
- Occupancy invariant: view_valid is thermometer-coded. Slots 0..count-1 are valid; all others are 0.
- Combinational outputs, taken from registers only:
  - in_ready = ~full. There is no bypass: an insert while full is refused even if a pop occurs in that cycle.
  - out_valid = view_valid[0]; out_key/out_payload = slot 0.
- Handshakes:
  - ins = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Inputs are sampled at the rising edge; results are visible the next cycle (latency 1).
- Ordering rule (ascending; for DESCENDING swap the comparison):
  - Let R = the old entries after the pop, i.e. old slots pop..count-1.
  - If ins, the new entry goes immediately after every entry in R with key ≤ in_key.
  - Ties are stable (FIFO among equal keys).
- Per-slot update rule: each slot j computes gt[j] = valid[j] & (key[j] > in_key), DESCENDING: <. Its new value then comes from its own old value, neighbour j+1 (pop), neighbour j-1 (insert shift), or the input. No global priority encoder is allowed; the comparison stays local, systolic style.
- Count update: count_next = count + ins − pop. Insert and pop in the same cycle leave count unchanged.
- Empty boundary: pop is impossible because out_valid=0. An insert into an empty array appears at slot 0 the next cycle.
- Full boundary: in_ready=0 and the array keeps its contents. A pop makes in_ready=1 on the next cycle.
- Same cycle insert+pop:
  - Old head leaves.
  - If in_key < every remaining key, the new entry becomes the head.
  - The popped entry's key is never compared against the new entry.
- Held inputs: in_key/in_payload may change freely while in_valid=0. Nothing is latched without ins.
- Payload travels with its key through all shifts and is never reordered independently.

Test Plan:
- Reset, then insert keys 5,3,9,3(payload B; first 3 has payload A) on consecutive cycles, ascending. Required: view_key=3,3,5,9 with payloads A,B,*,*; count=4; in_ready high every cycle.
- DESCENDING=1, DEPTH=4: insert 1,7,4,7,2. Required after the 4th insert: keys 7,7,4,1, full=1, in_ready=0; the 5th insert (key 2) is refused and contents are unchanged.
- Array holds 2,6,8; same cycle insert 1 and pop. Required: popped out_key=2; next cycle view_key=1,6,8, count=3.
- Array holds 2,6,8; same cycle insert 7 and pop. Required: next cycle 6,7,8, count=3.
- Full array (DEPTH=4): pop with in_valid=1. Required: the insert is refused that cycle; next cycle count=3 and in_ready=1; the insert then lands in order.
- Array holds 3 entries; assert flush together with insert and pop. Required: next cycle count=0, out_valid=0, all view_valid=0. Repeat the check with reset asserted mid-stream.
